// File: rtl/regfile_a_write_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_a_write_port (with package regfileAGroup)
// Brief    : 32x32 general register file + EPC, control-code driven write port,
//            two registered read ports with write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================

package regfileAGroup;
    typedef logic [3:0] controlBus;

    localparam controlBus NO_OP      = 4'd0;
    localparam controlBus NEXTPC_LR  = 4'd1;
    localparam controlBus SYSREG_DRL = 4'd2;
    localparam controlBus BREG_DRL   = 4'd3;
    localparam controlBus RESULT_DRL = 4'd4;
    localparam controlBus DWORD_DRL  = 4'd5;
    localparam controlBus SBYTE_DRL  = 4'd6;
    localparam controlBus SWORD_DRL  = 4'd7;
    localparam controlBus UBYTE_DRL  = 4'd8;
    localparam controlBus UWORD_DRL  = 4'd9;
    localparam controlBus NEXTPC_EPC = 4'd10;
endpackage

module regfile_a_write_port #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int LR_INDEX   = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  regfileAGroup::controlBus      regfileAControl,
    input  logic [$clog2(REG_COUNT)-1:0]  drlIndex,
    input  logic [DATA_WIDTH-1:0]         nextPc,
    input  logic [DATA_WIDTH-1:0]         sysregData,
    input  logic [DATA_WIDTH-1:0]         bRegData,
    input  logic [DATA_WIDTH-1:0]         resultData,
    input  logic [DATA_WIDTH-1:0]         memData,
    input  logic [1:0]                    memAddrLow,
    input  logic [$clog2(REG_COUNT)-1:0]  readIndexA,
    input  logic [$clog2(REG_COUNT)-1:0]  readIndexB,
    output logic [DATA_WIDTH-1:0]         readDataA,
    output logic [DATA_WIDTH-1:0]         readDataB,
    output logic [DATA_WIDTH-1:0]         epc,
    output logic                          writeValid
);
    import regfileAGroup::*;

    localparam int                 c_IDX_W    = $clog2(REG_COUNT);
    localparam logic [c_IDX_W-1:0] c_LR_INDEX = LR_INDEX[c_IDX_W-1:0];

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] r_epc;
    logic [DATA_WIDTH-1:0] r_rd_a;
    logic [DATA_WIDTH-1:0] r_rd_b;
    logic                  r_wv;

    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_gpr_we;
    logic                  w_epc_we;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;

    // Little-endian lane pick; memAddrLow[0] is deliberately ignored for halfwords.
    assign w_byte = memData[{memAddrLow, 3'b000} +: 8];
    assign w_half = memAddrLow[1] ? memData[31:16] : memData[15:0];

    always_comb begin
        w_gpr_we  = 1'b0;
        w_epc_we  = 1'b0;
        w_wr_idx  = drlIndex;
        w_wr_data = '0;
        case (regfileAControl)
            NEXTPC_LR: begin
                w_gpr_we  = 1'b1;
                w_wr_idx  = c_LR_INDEX;
                w_wr_data = nextPc;
            end
            SYSREG_DRL: begin
                w_gpr_we  = 1'b1;
                w_wr_data = sysregData;
            end
            BREG_DRL: begin
                w_gpr_we  = 1'b1;
                w_wr_data = bRegData;
            end
            RESULT_DRL: begin
                w_gpr_we  = 1'b1;
                w_wr_data = resultData;
            end
            DWORD_DRL: begin
                w_gpr_we  = 1'b1;
                w_wr_data = memData;
            end
            SBYTE_DRL: begin
                w_gpr_we  = 1'b1;
                w_wr_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            end
            UBYTE_DRL: begin
                w_gpr_we  = 1'b1;
                w_wr_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            end
            SWORD_DRL: begin
                w_gpr_we  = 1'b1;
                w_wr_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            end
            UWORD_DRL: begin
                w_gpr_we  = 1'b1;
                w_wr_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            end
            NEXTPC_EPC: begin
                w_epc_we  = 1'b1;
            end
            default: begin
                w_gpr_we  = 1'b0;
            end
        endcase
    end

    // EPC writes never reach the read ports because the bypass keys on w_gpr_we only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
            r_epc  <= '0;
            r_rd_a <= '0;
            r_rd_b <= '0;
            r_wv   <= 1'b0;
        end else if (enable) begin
            if (w_gpr_we) begin
                r_regs[w_wr_idx] <= w_wr_data;
            end
            if (w_epc_we) begin
                r_epc <= nextPc;
            end
            r_rd_a <= (w_gpr_we && (w_wr_idx == readIndexA)) ? w_wr_data : r_regs[readIndexA];
            r_rd_b <= (w_gpr_we && (w_wr_idx == readIndexB)) ? w_wr_data : r_regs[readIndexB];
            r_wv   <= w_gpr_we;
        end
    end

    assign readDataA  = r_rd_a;
    assign readDataB  = r_rd_b;
    assign epc        = r_epc;
    assign writeValid = r_wv;

endmodule
`default_nettype wire

// File: tb/tb_regfile_a_write_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_a_write_port
// Brief    : Vector table, directed stall/reset sequences and random traffic
//            checked against an architectural register-file model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_regfile_a_write_port;
    import regfileAGroup::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    controlBus   regfileAControl;
    logic [4:0]  drlIndex, readIndexA, readIndexB;
    logic [31:0] nextPc, sysregData, bRegData, resultData, memData;
    logic [1:0]  memAddrLow;
    logic [31:0] readDataA, readDataB, epc;
    logic        writeValid;

    regfile_a_write_port dut (
        .clk(clk), .reset(reset), .enable(enable),
        .regfileAControl(regfileAControl), .drlIndex(drlIndex),
        .nextPc(nextPc), .sysregData(sysregData), .bRegData(bRegData),
        .resultData(resultData), .memData(memData), .memAddrLow(memAddrLow),
        .readIndexA(readIndexA), .readIndexB(readIndexB),
        .readDataA(readDataA), .readDataB(readDataB),
        .epc(epc), .writeValid(writeValid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Architectural state: what software would observe.
    logic [31:0] m_regs [32];
    logic [31:0] m_epc, m_rda, m_rdb;
    logic        m_wv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_epc = 0; m_rda = 0; m_rdb = 0; m_wv = 0;
    endtask

    task automatic model_apply();
        int          idx;
        logic [31:0] val;
        logic [31:0] lane;
        if (!enable) return;
        idx = -1;
        val = 0;
        case (int'(regfileAControl))
            1:  begin idx = 31;           val = nextPc;     end
            2:  begin idx = int'(drlIndex); val = sysregData; end
            3:  begin idx = int'(drlIndex); val = bRegData;   end
            4:  begin idx = int'(drlIndex); val = resultData; end
            5:  begin idx = int'(drlIndex); val = memData;    end
            6, 8: begin
                idx  = int'(drlIndex);
                lane = (memData >> (8 * int'(memAddrLow))) & 32'hFF;
                val  = (regfileAControl == 4'd6 && lane >= 128) ? lane - 32'd256 : lane;
            end
            7, 9: begin
                idx  = int'(drlIndex);
                lane = (memAddrLow >= 2) ? (memData >> 16) : (memData & 32'hFFFF);
                val  = (regfileAControl == 4'd7 && lane >= 32768) ? lane - 32'd65536 : lane;
            end
            10: m_epc = nextPc;
            default: ;
        endcase
        if (idx >= 0) m_regs[idx] = val;
        m_wv  = (idx >= 0);
        m_rda = m_regs[readIndexA];
        m_rdb = m_regs[readIndexB];
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [4:0] drl, input logic [31:0] npc,
                         input logic [31:0] sys, input logic [31:0] br, input logic [31:0] res,
                         input logic [31:0] mem, input logic [1:0] al,
                         input logic [4:0] ia, input logic [4:0] ib, input logic en);
        regfileAControl = ctl; drlIndex = drl; nextPc = npc; sysregData = sys;
        bRegData = br; resultData = res; memData = mem; memAddrLow = al;
        readIndexA = ia; readIndexB = ib; enable = en;
    endtask

    task automatic tick_and_check();
        @(posedge clk);
        model_apply();
        @(negedge clk);
        check("model_readDataA", readDataA, m_rda);
        check("model_readDataB", readDataB, m_rdb);
        check("model_epc", epc, m_epc);
        check("model_writeValid", {31'b0, writeValid}, {31'b0, m_wv});
    endtask

    typedef struct {
        logic [3:0]  ctl;
        logic [4:0]  drl;
        logic [31:0] npc, sys, br, res, mem;
        logic [1:0]  al;
        logic [4:0]  ia, ib;
        logic [31:0] ea, eb, eepc;
        logic        ewv;
    } vec_t;

    localparam logic [31:0] S = 32'h5151_5151;
    localparam logic [31:0] B = 32'hB0B0_B0B0;
    localparam logic [31:0] R = 32'hAAAA_5555;
    localparam logic [31:0] M = 32'h9988_7766;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{4'd0,  5'd0, 32'h0,    S, B, R, M, 2'd0, 5'd0,  5'd31, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{4'd4,  5'd5, 32'h0,    S, B, 32'hDEADBEEF, M, 2'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1};
        tbl[2]  = '{4'd0,  5'd5, 32'h0,    S, B, R, M, 2'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0};
        tbl[3]  = '{4'd6,  5'd3, 32'h0,    S, B, R, 32'h12F45678, 2'd2, 5'd3, 5'd5, 32'hFFFFFFF4, 32'hDEADBEEF, 32'h0, 1'b1};
        tbl[4]  = '{4'd8,  5'd3, 32'h0,    S, B, R, 32'h12F45678, 2'd2, 5'd3, 5'd3, 32'h000000F4, 32'h000000F4, 32'h0, 1'b1};
        tbl[5]  = '{4'd7,  5'd4, 32'h0,    S, B, R, 32'h80017FFF, 2'd2, 5'd4, 5'd3, 32'hFFFF8001, 32'h000000F4, 32'h0, 1'b1};
        tbl[6]  = '{4'd7,  5'd4, 32'h0,    S, B, R, 32'h80017FFF, 2'd0, 5'd4, 5'd3, 32'h00007FFF, 32'h000000F4, 32'h0, 1'b1};
        tbl[7]  = '{4'd9,  5'd6, 32'h0,    S, B, R, 32'h80017FFF, 2'd3, 5'd6, 5'd4, 32'h00008001, 32'h00007FFF, 32'h0, 1'b1};
        tbl[8]  = '{4'd1,  5'd7, 32'h1004, S, B, R, M, 2'd0, 5'd31, 5'd7,  32'h00001004, 32'h0, 32'h0, 1'b1};
        tbl[9]  = '{4'd10, 5'd0, 32'h2000, S, B, R, M, 2'd0, 5'd31, 5'd0,  32'h00001004, 32'h0, 32'h2000, 1'b0};
        tbl[10] = '{4'd5,  5'd0, 32'h0,    S, B, R, 32'hCAFEF00D, 2'd1, 5'd0, 5'd1, 32'hCAFEF00D, 32'h0, 32'h2000, 1'b1};
        tbl[11] = '{4'd15, 5'd1, 32'h0,    S, B, R, M, 2'd0, 5'd1,  5'd0,  32'h0, 32'hCAFEF00D, 32'h2000, 1'b0};
        tbl[12] = '{4'd2,  5'd8, 32'h0,    32'h11112222, B, R, M, 2'd0, 5'd8, 5'd8, 32'h11112222, 32'h11112222, 32'h2000, 1'b1};
        tbl[13] = '{4'd3,  5'd9, 32'h0,    S, 32'h33334444, R, M, 2'd0, 5'd9, 5'd31, 32'h33334444, 32'h00001004, 32'h2000, 1'b1};

        reset = 1'b1;
        drive(4'd0, 5'd0, 32'h0, S, B, R, M, 2'd0, 5'd0, 5'd0, 1'b1);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_readDataA", readDataA, 32'h0);
        check("reset_readDataB", readDataB, 32'h0);
        check("reset_epc", epc, 32'h0);
        check("reset_writeValid", {31'b0, writeValid}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].ctl, tbl[i].drl, tbl[i].npc, tbl[i].sys, tbl[i].br, tbl[i].res,
                  tbl[i].mem, tbl[i].al, tbl[i].ia, tbl[i].ib, 1'b1);
            tick_and_check();
            check($sformatf("tbl%0d_readDataA", i), readDataA, tbl[i].ea);
            check($sformatf("tbl%0d_readDataB", i), readDataB, tbl[i].eb);
            check($sformatf("tbl%0d_epc", i), epc, tbl[i].eepc);
            check($sformatf("tbl%0d_writeValid", i), {31'b0, writeValid}, {31'b0, tbl[i].ewv});
        end

        // Stall: BREG write held off for three cycles, outputs frozen.
        for (int k = 0; k < 3; k++) begin
            drive(4'd3, 5'd10, 32'h0, S, 32'h77, R, M, 2'd0, 5'd10, 5'd5, 1'b0);
            tick_and_check();
            check("stall_readDataA", readDataA, 32'h33334444);
            check("stall_writeValid", {31'b0, writeValid}, 32'h1);
        end
        drive(4'd3, 5'd10, 32'h0, S, 32'h77, R, M, 2'd0, 5'd10, 5'd5, 1'b1);
        tick_and_check();
        check("unstall_readDataA", readDataA, 32'h77);
        check("unstall_readDataB", readDataB, 32'hDEADBEEF);

        // Asynchronous reset mid-cycle, held across an edge carrying a write.
        drive(4'd4, 5'd9, 32'h0, S, B, 32'h12345678, M, 2'd0, 5'd9, 5'd5, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_readDataA", readDataA, 32'h0);
        check("async_reset_readDataB", readDataB, 32'h0);
        check("async_reset_epc", epc, 32'h0);
        check("async_reset_writeValid", {31'b0, writeValid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'd0, 5'd0, 32'h0, S, B, R, M, 2'd0, 5'd9, 5'd5, 1'b1);
        tick_and_check();
        check("post_reset_r9", readDataA, 32'h0);
        check("post_reset_r5", readDataB, 32'h0);

        for (int i = 0; i < 32; i++) begin
            drive(4'd0, 5'd0, 32'h0, S, B, R, M, 2'd0, 5'(i), 5'(31 - i), 1'b1);
            tick_and_check();
        end

        for (int n = 0; n < 400; n++) begin
            drive(4'($urandom_range(0, 15)), 5'($urandom), $urandom, $urandom, $urandom,
                  $urandom, $urandom, 2'($urandom), 5'($urandom), 5'($urandom),
                  ($urandom_range(0, 9) != 0));
            tick_and_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
